// File: rtl/timestamp_multi_pkg.sv
// Shared definitions for the multi-channel timestamp core.
//  - register map, VERSION value
//  - data word layout (header / hi-lo flag / channel / 24-bit timestamp slice)
//  - arbiter FSM state encoding
package timestamp_multi_pkg;

  localparam int REG_SOFT_RST = 0;  // W: soft reset, R: VERSION
  localparam int REG_CONF     = 1;  // [0] EN, [1] EXT_TS
  localparam int REG_CH_EN    = 2;
  localparam int REG_FALL     = 3;
  localparam int REG_LOST     = 4;
  localparam int REG_LEVEL    = 5;

  localparam logic [7:0] VERSION = 8'd1;

  // Data word layout
  localparam int HDR_LSB  = 28;
  localparam int FLAG_BIT = 27;  // 1 = upper timestamp half (word0)
  localparam int CH_LSB   = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2
  } arb_state_e;

  function automatic logic [31:0] make_word(input logic [3:0]  id,
                                            input logic        hi,
                                            input logic [2:0]  ch,
                                            input logic [23:0] ts24);
    logic [31:0] w;
    w                        = '0;
    w[HDR_LSB+3:HDR_LSB]     = id;
    w[FLAG_BIT]              = hi;
    w[CH_LSB+2:CH_LSB]       = ch;
    w[23:0]                  = ts24;
    return w;
  endfunction

endpackage

// File: rtl/timestamp_multi_fifo.sv
// Synchronous first-word-fall-through FIFO.
//  clk      clock
//  rst_n    synchronous reset, active low
//  clr      synchronous clear (soft reset), active high
//  wr_en    push wr_data (ignored when full)
//  rd_en    pop head (ignored when empty)
//  rd_data  head word, valid while !empty
//  empty    no data
//  level    number of stored words, 0..DEPTH
module timestamp_multi_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             push, pop;

  assign push = wr_en && (cnt != (AW+1)'(DEPTH));
  assign pop  = rd_en && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  assign rd_data = mem[rptr];
  assign empty   = (cnt == '0);
  assign level   = cnt;

endmodule

// File: rtl/timestamp_multi_core.sv
// Multi-channel hit timestamp core.
//  Each DI channel is synchronised, edge-detected (rising or falling per channel),
//  and captures the current time base into a per-channel register. A round-robin
//  arbiter drains captured events into a shared FWFT FIFO as atomic word pairs.
// Ports:
//  BUS_CLK, BUS_RST_N           clock, synchronous active-low reset
//  BUS_ADD/DATA_IN/RD/WR        8-bit register bus, BUS_DATA_OUT registered
//  DI                           async hit inputs
//  EXT_TIMESTAMP                external time base
//  TIMESTAMP_OUT                internal counter
//  FIFO_READ/EMPTY/DATA         FIFO source interface to the readout arbiter
module timestamp_multi_core
  import timestamp_multi_pkg::*;
#(
  parameter int         ABUSWIDTH  = 16,
  parameter logic [3:0] IDENTIFIER = 4'b0001,
  parameter int         CHANNELS   = 4,
  parameter int         TS_WIDTH   = 48,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic [CHANNELS-1:0]  DI,
  input  logic [TS_WIDTH-1:0]  EXT_TIMESTAMP,
  output logic [TS_WIDTH-1:0]  TIMESTAMP_OUT,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- register bus ----------------
  logic soft_rst, clr;
  logic conf_en, conf_ext;
  logic [CHANNELS-1:0] ch_en, fall;
  logic [7:0] lost;
  logic [LW-1:0] fifo_level;

  function automatic logic addr_is(input logic [ABUSWIDTH-1:0] a, input int r);
    return a == ABUSWIDTH'(r);
  endfunction

  // Soft reset acts in the very cycle of the write, so everything below sees
  // a single combined clear.
  assign soft_rst = BUS_WR && addr_is(BUS_ADD, REG_SOFT_RST);
  assign clr      = !BUS_RST_N || soft_rst;

  always_ff @(posedge BUS_CLK) begin
    if (clr) begin
      conf_en  <= 1'b0;
      conf_ext <= 1'b0;
      ch_en    <= '0;
      fall     <= '0;
    end else if (BUS_WR) begin
      if (addr_is(BUS_ADD, REG_CONF)) begin
        conf_en  <= BUS_DATA_IN[0];
        conf_ext <= BUS_DATA_IN[1];
      end
      if (addr_is(BUS_ADD, REG_CH_EN)) ch_en <= BUS_DATA_IN[CHANNELS-1:0];
      if (addr_is(BUS_ADD, REG_FALL))  fall  <= BUS_DATA_IN[CHANNELS-1:0];
    end
  end

  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'h00;
    if (addr_is(BUS_ADD, REG_SOFT_RST)) rd_mux = VERSION;
    if (addr_is(BUS_ADD, REG_CONF))     rd_mux = {6'd0, conf_ext, conf_en};
    if (addr_is(BUS_ADD, REG_CH_EN))    rd_mux = 8'(ch_en);
    if (addr_is(BUS_ADD, REG_FALL))     rd_mux = 8'(fall);
    if (addr_is(BUS_ADD, REG_LOST))     rd_mux = lost;
    if (addr_is(BUS_ADD, REG_LEVEL))
      rd_mux = (int'(fifo_level) > 255) ? 8'hFF : 8'(fifo_level);
  end

  always_ff @(posedge BUS_CLK) begin
    if (clr)         BUS_DATA_OUT <= 8'h00;
    else if (BUS_RD) BUS_DATA_OUT <= rd_mux;
  end

  // ---------------- time base ----------------
  logic [TS_WIDTH-1:0] cnt, ts;

  always_ff @(posedge BUS_CLK) begin
    if (clr)          cnt <= '0;
    else if (conf_en) cnt <= cnt + 1'b1;
  end

  assign TIMESTAMP_OUT = cnt;
  assign ts            = conf_ext ? EXT_TIMESTAMP : cnt;

  // ---------------- per-channel sync / edge detect ----------------
  logic [CHANNELS-1:0] sync1, sync2, prev, hit, pending, lost_hit;

  // prev always tracks sync2 so config changes never fabricate an edge.
  always_ff @(posedge BUS_CLK) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= DI;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign hit = {CHANNELS{conf_en}} & ch_en &
               ((fall & ~sync2 & prev) | (~fall & sync2 & ~prev));
  assign lost_hit = hit & pending;

  // ---------------- LOST counter ----------------
  logic [3:0] lost_inc;
  logic [8:0] lost_sum;

  always_comb begin
    lost_inc = '0;
    for (int c = 0; c < CHANNELS; c++) lost_inc = lost_inc + 4'(lost_hit[c]);
    lost_sum = {1'b0, lost} + 9'(lost_inc);
  end

  always_ff @(posedge BUS_CLK) begin
    if (clr)                                  lost <= 8'h00;
    else if (BUS_WR && addr_is(BUS_ADD, REG_LOST)) lost <= 8'h00;
    else if (lost_sum[8])                     lost <= 8'hFF;
    else                                      lost <= lost_sum[7:0];
  end

  // ---------------- capture ----------------
  logic [CHANNELS-1:0][TS_WIDTH-1:0] cap;
  logic [2:0] serve_ch, last_ch;
  logic       clr_pend;

  // A channel's capture is frozen while pending, so the arbiter can read it
  // across both word cycles.
  always_ff @(posedge BUS_CLK) begin
    if (clr) begin
      pending <= '0;
      cap     <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (hit[c] && !pending[c]) begin
          pending[c] <= 1'b1;
          cap[c]     <= ts;
        end else if (clr_pend && serve_ch == 3'(c)) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  // ---------------- round-robin arbiter ----------------
  arb_state_e state, next_state;
  logic       pick_vld;
  logic [2:0] pick_ch;
  logic       room;
  logic       fifo_wr;
  logic [31:0] fifo_wdata;
  logic [47:0] ts48;

  // Search starts one past the last served channel and wraps.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!pick_vld && pending[(int'(last_ch) + i) % CHANNELS]) begin
        pick_vld = 1'b1;
        pick_ch  = 3'((int'(last_ch) + i) % CHANNELS);
      end
    end
  end

  // Room for a full pair is required up front so pairs are never split.
  assign room = int'(fifo_level) <= FIFO_DEPTH - 2;

  always_ff @(posedge BUS_CLK) begin
    if (clr) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (pick_vld && room) next_state = ST_W0;
      ST_W0:   next_state = ST_W1;
      ST_W1:   next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign ts48 = 48'(cap[serve_ch]);

  always_comb begin
    fifo_wr    = 1'b0;
    clr_pend   = 1'b0;
    fifo_wdata = '0;
    case (state)
      ST_W0: begin
        fifo_wr    = 1'b1;
        fifo_wdata = make_word(IDENTIFIER, 1'b1, serve_ch, ts48[47:24]);
      end
      ST_W1: begin
        fifo_wr    = 1'b1;
        clr_pend   = 1'b1;
        fifo_wdata = make_word(IDENTIFIER, 1'b0, serve_ch, ts48[23:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (clr) begin
      serve_ch <= '0;
      last_ch  <= '0;
    end else begin
      if (state == ST_IDLE && next_state == ST_W0) serve_ch <= pick_ch;
      if (state == ST_W1) last_ch <= serve_ch;
    end
  end

  // ---------------- FIFO ----------------
  timestamp_multi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (BUS_CLK),
    .rst_n   (BUS_RST_N),
    .clr     (soft_rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (FIFO_READ),
    .rd_data (FIFO_DATA),
    .empty   (FIFO_EMPTY),
    .level   (fifo_level)
  );

endmodule
